// File: rtl/i2c_bus_mux.sv
// i2c_bus_mux: run-time I2C bus multiplexer and switch scheduler.
// Connects one of NumBuses physical I2C buses to a single I2C host
// controller. A bus switch waits until the active bus has been idle for
// IdleCycles, then releases every bus for GuardCycles before connecting
// the new one. START/STOP on the active bus are tracked (bus_busy_o), and
// the active bus is mirrored on registered monitor outputs.
//
// Ports:
//   clk_sys_i, rst_sys_i          clock, asynchronous active-high reset
//   sel_req_i, sel_req_valid_i    requested bus index + one-cycle strobe
//   sel_active_o                  currently connected bus
//   sel_busy_o                    switch pending or in progress
//   sel_err_o                     one-cycle pulse: request index out of range
//   bus_busy_o                    START seen on active bus, not yet ended
//   ctrl_{scl,sda}_o/_en_o        drive from the controller
//   ctrl_{scl,sda}_i              bus lines returned to the controller
//   bus_{scl,sda}_i               pad inputs, one bit per bus
//   bus_{scl,sda}_o/_en_o         pad open-drain drive, one bit per bus
//   mon_{scl,sda}_o               registered mirror of the active bus
module i2c_bus_mux #(
    parameter int unsigned NumBuses    = 4,
    parameter int unsigned SelW        = $clog2(NumBuses),
    parameter int unsigned IdleCycles  = 250,
    parameter int unsigned GuardCycles = 16
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_i,
    input  logic [SelW-1:0]     sel_req_i,
    input  logic                sel_req_valid_i,
    output logic [SelW-1:0]     sel_active_o,
    output logic                sel_busy_o,
    output logic                sel_err_o,
    output logic                bus_busy_o,
    input  logic                ctrl_scl_o,
    input  logic                ctrl_scl_en_o,
    input  logic                ctrl_sda_o,
    input  logic                ctrl_sda_en_o,
    output logic                ctrl_scl_i,
    output logic                ctrl_sda_i,
    input  logic [NumBuses-1:0] bus_scl_i,
    input  logic [NumBuses-1:0] bus_sda_i,
    output logic [NumBuses-1:0] bus_scl_o,
    output logic [NumBuses-1:0] bus_scl_en_o,
    output logic [NumBuses-1:0] bus_sda_o,
    output logic [NumBuses-1:0] bus_sda_en_o,
    output logic                mon_scl_o,
    output logic                mon_sda_o
);

    localparam int unsigned IdleW  = $clog2(IdleCycles + 1);
    localparam int unsigned GuardW = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;
    localparam logic [IdleW-1:0]  IdleMax   = IdleW'(IdleCycles);
    localparam logic [GuardW-1:0] GuardLast = GuardW'(GuardCycles - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_WAIT_IDLE,
        ST_SWITCH
    } state_e;

    state_e              state_q;
    logic [SelW-1:0]     sel_active_q;
    logic [SelW-1:0]     target_q;
    logic [GuardW-1:0]   guard_cnt_q;
    logic                sel_busy_q;
    logic                sel_err_q;
    logic                bus_busy_q;
    logic [IdleW-1:0]    idle_cnt_q;
    logic                prev_sda_q;
    logic                mon_scl_q;
    logic                mon_sda_q;
    logic [NumBuses-1:0] scl_s1_q, scl_s2_q;
    logic [NumBuses-1:0] sda_s1_q, sda_s2_q;

    logic act_scl, act_sda;
    logic idle, start_det, stop_det;
    logic req_in_range, req_ok, switch_done;

    assign act_scl      = scl_s2_q[sel_active_q];
    assign act_sda      = sda_s2_q[sel_active_q];
    assign idle         = (idle_cnt_q == IdleMax);
    assign start_det    = prev_sda_q & ~act_sda & act_scl;
    assign stop_det     = ~prev_sda_q & act_sda & act_scl;
    assign req_in_range = (32'(sel_req_i) < NumBuses);
    assign req_ok       = sel_req_valid_i & req_in_range;
    assign switch_done  = (state_q == ST_SWITCH) && (guard_cnt_q == GuardLast);

    assign sel_active_o = sel_active_q;
    assign sel_busy_o   = sel_busy_q;
    assign sel_err_o    = sel_err_q;
    assign bus_busy_o   = bus_busy_q;
    assign mon_scl_o    = mon_scl_q;
    assign mon_sda_o    = mon_sda_q;

    // Pass-through datapath: only the active bus is driven, none while switching.
    always_comb begin
        bus_scl_o    = '1;
        bus_scl_en_o = '0;
        bus_sda_o    = '1;
        bus_sda_en_o = '0;
        ctrl_scl_i   = 1'b1;
        ctrl_sda_i   = 1'b1;
        if (state_q != ST_SWITCH) begin
            bus_scl_o[sel_active_q]    = ctrl_scl_o;
            bus_scl_en_o[sel_active_q] = ctrl_scl_en_o;
            bus_sda_o[sel_active_q]    = ctrl_sda_o;
            bus_sda_en_o[sel_active_q] = ctrl_sda_en_o;
            ctrl_scl_i                 = bus_scl_i[sel_active_q];
            ctrl_sda_i                 = bus_sda_i[sel_active_q];
        end
    end

    // Two-flop synchronizers on every pad line, idle-high at reset.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            scl_s1_q <= '1;
            scl_s2_q <= '1;
            sda_s1_q <= '1;
            sda_s2_q <= '1;
        end else begin
            scl_s1_q <= bus_scl_i;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= bus_sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

    // Active-bus tracking: START/STOP, idle counter and monitor mirror.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            bus_busy_q <= 1'b0;
            idle_cnt_q <= '0;
            prev_sda_q <= 1'b1;
            mon_scl_q  <= 1'b1;
            mon_sda_q  <= 1'b1;
        end else begin
            mon_scl_q <= (state_q == ST_SWITCH) ? 1'b1 : act_scl;
            mon_sda_q <= (state_q == ST_SWITCH) ? 1'b1 : act_sda;
            if (switch_done) begin
                // History restarts from the new bus so no false edge is seen.
                bus_busy_q <= 1'b0;
                idle_cnt_q <= '0;
                prev_sda_q <= sda_s2_q[target_q];
            end else begin
                prev_sda_q <= act_sda;
                if (act_scl && act_sda) begin
                    if (!idle) begin
                        idle_cnt_q <= idle_cnt_q + IdleW'(1);
                    end
                end else begin
                    idle_cnt_q <= '0;
                end
                // A long idle stretch also ends a transfer whose STOP was lost.
                if (start_det) begin
                    bus_busy_q <= 1'b1;
                end else if (stop_det || idle) begin
                    bus_busy_q <= 1'b0;
                end
            end
        end
    end

    // Switch scheduler.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q      <= ST_ACTIVE;
            sel_active_q <= '0;
            target_q     <= '0;
            guard_cnt_q  <= '0;
            sel_busy_q   <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            sel_err_q <= sel_req_valid_i & ~req_in_range;
            case (state_q)
                ST_ACTIVE: begin
                    if (req_ok && (sel_req_i != sel_active_q)) begin
                        target_q    <= sel_req_i;
                        guard_cnt_q <= '0;
                        sel_busy_q  <= 1'b1;
                        state_q     <= idle ? ST_SWITCH : ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (req_ok && (sel_req_i == sel_active_q)) begin
                        state_q    <= ST_ACTIVE;
                        sel_busy_q <= 1'b0;
                    end else begin
                        if (req_ok) begin
                            target_q <= sel_req_i;
                        end
                        if (idle) begin
                            guard_cnt_q <= '0;
                            state_q     <= ST_SWITCH;
                        end
                    end
                end
                ST_SWITCH: begin
                    // Requests are dropped here, not queued.
                    if (switch_done) begin
                        sel_active_q <= target_q;
                        sel_busy_q   <= 1'b0;
                        state_q      <= ST_ACTIVE;
                    end else begin
                        guard_cnt_q <= guard_cnt_q + GuardW'(1);
                    end
                end
                default: begin
                    state_q    <= ST_ACTIVE;
                    sel_busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_mux.sv
// Testbench for i2c_bus_mux: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the mux.
module tb_i2c_bus_mux;

    localparam int NB    = 5;
    localparam int SW    = 3;
    localparam int IDLE  = 250;
    localparam int GUARD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] req;
    logic          req_valid;
    logic [SW-1:0] sel_active_o;
    logic          sel_busy_o, sel_err_o, bus_busy_o;
    logic          c_scl, c_scl_en, c_sda, c_sda_en;
    logic          ctrl_scl_i, ctrl_sda_i;
    logic [NB-1:0] p_scl, p_sda;
    logic [NB-1:0] bus_scl_o, bus_scl_en_o, bus_sda_o, bus_sda_en_o;
    logic          mon_scl_o, mon_sda_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i2c_bus_mux #(
        .NumBuses(NB), .IdleCycles(IDLE), .GuardCycles(GUARD)
    ) dut (
        .clk_sys_i(clk), .rst_sys_i(rst),
        .sel_req_i(req), .sel_req_valid_i(req_valid),
        .sel_active_o(sel_active_o), .sel_busy_o(sel_busy_o),
        .sel_err_o(sel_err_o), .bus_busy_o(bus_busy_o),
        .ctrl_scl_o(c_scl), .ctrl_scl_en_o(c_scl_en),
        .ctrl_sda_o(c_sda), .ctrl_sda_en_o(c_sda_en),
        .ctrl_scl_i(ctrl_scl_i), .ctrl_sda_i(ctrl_sda_i),
        .bus_scl_i(p_scl), .bus_sda_i(p_sda),
        .bus_scl_o(bus_scl_o), .bus_scl_en_o(bus_scl_en_o),
        .bus_sda_o(bus_sda_o), .bus_sda_en_o(bus_sda_en_o),
        .mon_scl_o(mon_scl_o), .mon_sda_o(mon_sda_o)
    );

    // Reference model: pad values seen two cycles late, a pending flag and a
    // countdown of remaining guard cycles.
    bit m_d1_scl [NB];
    bit m_d1_sda [NB];
    bit m_d2_scl [NB];
    bit m_d2_sda [NB];
    int m_active, m_target, m_idle, m_sw_left;
    bit m_pending, m_busy, m_prev_sda, m_err, m_mon_scl, m_mon_sda;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            m_d1_scl[k] = 1'b1; m_d1_sda[k] = 1'b1;
            m_d2_scl[k] = 1'b1; m_d2_sda[k] = 1'b1;
        end
        m_active = 0; m_target = 0; m_idle = 0; m_sw_left = 0;
        m_pending = 1'b0; m_busy = 1'b0; m_prev_sda = 1'b1; m_err = 1'b0;
        m_mon_scl = 1'b1; m_mon_sda = 1'b1;
    endtask

    task automatic model_step();
        bit a_scl, a_sda, was_idle, in_sw, start, stop, ok;
        if (rst) begin
            model_reset();
            return;
        end
        a_scl    = m_d2_scl[m_active];
        a_sda    = m_d2_sda[m_active];
        was_idle = (m_idle == IDLE);
        in_sw    = (m_sw_left > 0);
        start    = m_prev_sda && !a_sda && a_scl;
        stop     = !m_prev_sda && a_sda && a_scl;
        ok       = req_valid && (int'(req) < NB);
        m_err    = req_valid && (int'(req) >= NB);
        m_mon_scl = in_sw ? 1'b1 : a_scl;
        m_mon_sda = in_sw ? 1'b1 : a_sda;
        if (m_sw_left == 1) begin
            m_active   = m_target;
            m_busy     = 1'b0;
            m_idle     = 0;
            m_prev_sda = m_d2_sda[m_target];
        end else begin
            if (start) m_busy = 1'b1;
            else if (stop || was_idle) m_busy = 1'b0;
            if (a_scl && a_sda) m_idle = (m_idle < IDLE) ? m_idle + 1 : IDLE;
            else m_idle = 0;
            m_prev_sda = a_sda;
        end
        if (in_sw) begin
            m_sw_left--;
        end else if (!m_pending) begin
            if (ok && int'(req) != m_active) begin
                m_target = int'(req);
                if (was_idle) m_sw_left = GUARD;
                else m_pending = 1'b1;
            end
        end else begin
            if (ok && int'(req) == m_active) begin
                m_pending = 1'b0;
            end else begin
                if (ok) m_target = int'(req);
                if (was_idle) begin
                    m_pending = 1'b0;
                    m_sw_left = GUARD;
                end
            end
        end
        for (int k = 0; k < NB; k++) begin
            m_d2_scl[k] = m_d1_scl[k]; m_d2_sda[k] = m_d1_sda[k];
            m_d1_scl[k] = p_scl[k];    m_d1_sda[k] = p_sda[k];
        end
    endtask

    task automatic check_all();
        logic [NB-1:0] e_scl, e_scl_en, e_sda, e_sda_en;
        logic e_cscl, e_csda;
        e_scl = '1; e_scl_en = '0; e_sda = '1; e_sda_en = '0;
        e_cscl = 1'b1; e_csda = 1'b1;
        if (m_sw_left == 0) begin
            e_scl[m_active] = c_scl; e_scl_en[m_active] = c_scl_en;
            e_sda[m_active] = c_sda; e_sda_en[m_active] = c_sda_en;
            e_cscl = p_scl[m_active]; e_csda = p_sda[m_active];
        end
        chk("sel_active", 32'(sel_active_o), 32'(m_active));
        chk("sel_busy", 32'(sel_busy_o), 32'(m_pending || (m_sw_left > 0)));
        chk("sel_err", 32'(sel_err_o), 32'(m_err));
        chk("bus_busy", 32'(bus_busy_o), 32'(m_busy));
        chk("mon_scl", 32'(mon_scl_o), 32'(m_mon_scl));
        chk("mon_sda", 32'(mon_sda_o), 32'(m_mon_sda));
        chk("bus_scl_o", 32'(bus_scl_o), 32'(e_scl));
        chk("bus_scl_en", 32'(bus_scl_en_o), 32'(e_scl_en));
        chk("bus_sda_o", 32'(bus_sda_o), 32'(e_sda));
        chk("bus_sda_en", 32'(bus_sda_en_o), 32'(e_sda_en));
        chk("ctrl_scl_i", 32'(ctrl_scl_i), 32'(e_cscl));
        chk("ctrl_sda_i", 32'(ctrl_sda_i), 32'(e_csda));
    endtask

    // One clock: model advances on the rising edge, outputs checked on the falling edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
            c_scl    = 1'($urandom_range(0, 1));
            c_scl_en = 1'($urandom_range(0, 1));
            c_sda    = 1'($urandom_range(0, 1));
            c_sda_en = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic request(input int idx);
        req = SW'(idx);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; req_valid = 1'b0;
        c_scl = 1'b1; c_scl_en = 1'b0; c_sda = 1'b1; c_sda_en = 1'b0;
        p_scl = '1; p_sda = '1;
        model_reset();
        #1;
        chk("rst_scl_en", 32'(bus_scl_en_o), 32'h0);
        chk("rst_sda_en", 32'(bus_sda_en_o), 32'h0);
        chk("rst_active", 32'(sel_active_o), 32'h0);
        chk("rst_mon", 32'({mon_scl_o, mon_sda_o}), 32'h3);
        chk("rst_busy", 32'(sel_busy_o), 32'h0);
        tick(3);
        rst = 1'b0;
        tick(260);

        // Idle switch to bus 2.
        request(2);
        chk("isw_busy", 32'(sel_busy_o), 32'h1);
        chk("isw_en_off", 32'(bus_scl_en_o | bus_sda_en_o), 32'h0);
        tick(15);
        chk("isw_still0", 32'(sel_active_o), 32'h0);
        tick();
        chk("isw_active2", 32'(sel_active_o), 32'h2);
        chk("isw_busy_done", 32'(sel_busy_o), 32'h0);
        c_scl_en = 1'b1; p_scl[2] = 1'b0;
        #1;
        chk("isw_en_bus2", 32'(bus_scl_en_o), 32'h4);
        chk("isw_ctrl_scl", 32'(ctrl_scl_i), 32'h0);
        p_scl[2] = 1'b1;
        tick(2);

        // Deferred switch: START on bus 2, request bus 1.
        p_sda[2] = 1'b0;
        tick(3);
        chk("def_busbusy", 32'(bus_busy_o), 32'h1);
        request(1);
        chk("def_pending", 32'(sel_busy_o), 32'h1);
        for (int i = 0; i < 20; i++) begin
            p_scl[2] = ~p_scl[2];
            tick(2);
        end
        chk("def_still2", 32'(sel_active_o), 32'h2);
        p_scl[2] = 1'b1; tick(2);
        p_sda[2] = 1'b1; tick(3);
        chk("def_stop", 32'(bus_busy_o), 32'h0);
        tick(280);
        chk("def_active1", 32'(sel_active_o), 32'h1);

        // Lost STOP on bus 1: SDA rises while SCL low.
        p_sda[1] = 1'b0; tick(4);
        p_scl[1] = 1'b0; tick(2);
        p_sda[1] = 1'b1; tick(2);
        p_scl[1] = 1'b1; tick(3);
        chk("lost_busy", 32'(bus_busy_o), 32'h1);
        request(3);
        tick(240);
        chk("lost_busy_hold", 32'(bus_busy_o), 32'h1);
        tick(40);
        chk("lost_active3", 32'(sel_active_o), 32'h3);
        chk("lost_busy_clr", 32'(bus_busy_o), 32'h0);

        // Monitor follows bus 3; inactive-bus toggles are ignored.
        p_sda[3] = 1'b0; p_sda[0] = 1'b0; p_scl[4] = 1'b0;
        tick(2);
        chk("mon_lat2", 32'(mon_sda_o), 32'h1);
        tick();
        chk("mon_lat3", 32'(mon_sda_o), 32'h0);
        p_sda[3] = 1'b1; p_sda[0] = 1'b1; p_scl[4] = 1'b1;
        tick(3);
        chk("mon_back", 32'(mon_sda_o), 32'h1);

        // Out-of-range request.
        request(5);
        chk("err_pulse", 32'(sel_err_o), 32'h1);
        chk("err_nochange", 32'(sel_busy_o), 32'h0);
        tick();
        chk("err_clear", 32'(sel_err_o), 32'h0);

        // Cancel from WAIT_IDLE by requesting the active bus.
        p_sda[3] = 1'b0; tick(4);
        request(0);
        chk("can_pending", 32'(sel_busy_o), 32'h1);
        request(3);
        chk("can_cleared", 32'(sel_busy_o), 32'h0);
        p_sda[3] = 1'b1; tick(260);

        // Request during SWITCH is dropped.
        request(1);
        tick(3);
        request(4);
        tick(11);
        chk("sw_ign_busy", 32'(sel_busy_o), 32'h1);
        tick();
        chk("sw_ign_active", 32'(sel_active_o), 32'h1);
        chk("sw_ign_noqueue", 32'(sel_busy_o), 32'h0);

        // Reset in the middle of a switch.
        tick(255);
        request(2);
        tick(4);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mrst_active", 32'(sel_active_o), 32'h0);
        chk("mrst_busy", 32'(sel_busy_o), 32'h0);
        tick(2);
        rst = 1'b0;
        tick();
        chk("mrst_after", 32'(sel_active_o), 32'h0);

        // Randomized traffic, idle stretches and requests.
        for (int seg = 0; seg < 45; seg++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 2);
            len  = (kind == 0) ? $urandom_range(255, 300) : $urandom_range(10, 60);
            if (kind == 0) begin
                p_scl = '1; p_sda = '1;
            end
            for (int c = 0; c < len; c++) begin
                if (kind == 0) begin
                    for (int k = 0; k < NB; k++) begin
                        if (k != m_active && $urandom_range(0, 3) == 0) begin
                            p_sda[k] = ~p_sda[k];
                        end
                    end
                end else if (kind == 1) begin
                    p_scl = NB'($urandom);
                    p_sda = NB'($urandom);
                end else begin
                    if ($urandom_range(0, 1) == 1) p_scl[m_active] = ~p_scl[m_active];
                    else p_sda[m_active] = ~p_sda[m_active];
                end
                req       = SW'($urandom_range(0, 7));
                req_valid = ($urandom_range(0, 15) == 0);
                tick();
            end
            req_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_bus_mux.md
# i2c_bus_mux

Runtime I2C bus multiplexer and switch scheduler placed between the I2C1 host controller and the physical I2C buses: QWIIC J7, RPi HAT GPIO2/3, RPi HAT ID EEPROM GPIO0/1 and mikroBUS. It connects one selected bus to the controller. Software selects the bus at run time rather than at build time. A switch is deferred until the active bus has been idle long enough, then all buses are released for a guard period before the new bus is connected. It tracks START/STOP on the active bus and mirrors that bus on a registered monitor output for a logic analyser.

## Interface
Parameters:
- NumBuses, 4: number of physical buses (≥2).
- SelW, $clog2(NumBuses): select width (derived).
- IdleCycles, 250: consecutive cycles with SCL=SDA=1 required before switching (5 µs at 50 MHz).
- GuardCycles, 16: cycles all buses are released during a switch (≥1).

Ports:
- clk_sys_i  in  1  system clock (one clock domain).
- rst_sys_i  in  1  reset, asynchronous, active-high.
- sel_req_i  in  SelW  requested bus index.
- sel_req_valid_i  in  1  one-cycle request strobe.
- sel_active_o  out  SelW  currently connected bus.
- sel_busy_o  out  1  switch pending or in progress.
- sel_err_o  out  1  one-cycle pulse: request index ≥ NumBuses.
- bus_busy_o  out  1  START seen on active bus, no STOP/idle-timeout yet.
- ctrl_scl_o, ctrl_scl_en_o, ctrl_sda_o, ctrl_sda_en_o  in  1 each  from I2C controller.
- ctrl_scl_i, ctrl_sda_i  out  1 each  to I2C controller.
- bus_scl_i, bus_sda_i  in  NumBuses  pad inputs.
- bus_scl_o, bus_scl_en_o, bus_sda_o, bus_sda_en_o  out  NumBuses  pad open-drain drive.
- mon_scl_o, mon_sda_o  out  1 each  registered mirror of active bus.

## Operation
- Datapath, combinational:
  - For k==sel_active and state≠SWITCH: bus_*_o[k] = ctrl_*_o and bus_*_en_o[k] = ctrl_*_en_o.
  - All other buses: o=1, en=0.
  - ctrl_scl_i/ctrl_sda_i = raw bus_*_i[sel_active]; forced 1 in SWITCH.
- Monitor: each bus line passes through a 2-flop synchronizer (reset 1). Bus-state logic uses only the synced values of the active bus.
- START = synced SDA 1→0 while SCL=1. STOP = SDA 0→1 while SCL=1.
- bus_busy set on START; cleared on STOP or when idle_cnt reaches IdleCycles.
- idle_cnt counts consecutive cycles with synced SCL=SDA=1, saturating at IdleCycles. It is zeroed on any cycle with either line low. Idle means idle_cnt==IdleCycles.
- FSM states are ACTIVE, WAIT_IDLE and SWITCH.
  - ACTIVE, valid request with idx<NumBuses and idx≠sel_active: latch target. Go to SWITCH if idle, else WAIT_IDLE.
  - ACTIVE, idx==sel_active: ignored.
  - WAIT_IDLE: a new valid request overwrites target. A request equal to sel_active cancels and returns to ACTIVE. Go to SWITCH when idle.
  - SWITCH: guard counter runs GuardCycles cycles. Requests are ignored and not queued. On exit: sel_active←target, bus_busy←0, idle_cnt←0, edge-detect history←synced lines of target. Then return to ACTIVE.
- Any idx≥NumBuses in any state: sel_err_o pulses the next cycle; state is unchanged.
- sel_busy_o = (state≠ACTIVE).
- Reset values:
  - state ACTIVE, sel_active_o 0, target 0.
  - sel_busy_o 0, sel_err_o 0, bus_busy_o 0, idle_cnt 0, guard counter 0.
  - Synchronizers 1, mon_scl_o/mon_sda_o 1.
  - All bus_*_en_o 0 while ctrl_*_en_o=0.
- Reset mid-switch: returns immediately to bus 0 in ACTIVE.

## Timing
- Datapath pass-through: 0 cycles, combinational.
- Pad → mon_*_o: 3 cycles (2 sync + 1 register). mon outputs hold 1 during SWITCH.
- Pad → START/STOP detection → bus_busy_o: 3 cycles.
- Request at cycle N with bus idle:
  - SWITCH spans N+1 … N+GuardCycles; all en=0.
  - sel_active_o changes and the new bus connects at N+GuardCycles+1.
  - sel_busy_o is high from N+1 through N+GuardCycles.
- Request while not idle: WAIT_IDLE from N+1. SWITCH starts the cycle after idle_cnt saturates.
- Simultaneous request and saturation in WAIT_IDLE: new target taken, enter SWITCH next cycle.
- idle_cnt width ≥ $clog2(IdleCycles+1); no wrap (saturates).

## Test plan
- Reset: all en=0, sel_active_o=0, mon=1, sel_busy_o=0. Assert reset mid-SWITCH → next cycle ACTIVE, sel_active_o=0.
- Idle switch: buses high ≥250 cycles, request 2 at N → en all 0 for N+1..N+16; bus 2 driven and sel_active_o=2 at N+17. ctrl_scl_i reads bus 2 pad.
- Deferred switch: START on bus 0, request 1 → sel_busy_o=1, bus 0 stays connected. STOP then 250 idle cycles → SWITCH. No glitch on bus 0 en during transfer.
- Lost STOP: START, then lines held high → bus_busy_o clears after 250 cycles; pending switch proceeds.
- Request handling: request 5 → sel_err_o 1-cycle pulse, no state change. Request equal to active during WAIT_IDLE → cancels, sel_busy_o=0. Request during SWITCH → ignored.
- Monitor: toggle bus 3 SDA while bus 3 active → mon_sda_o follows 3 cycles later. Toggling inactive buses has no effect on mon_*_o, bus_busy_o or ctrl_*_i.
